// File: rtl/cu_dcdr_pipe.sv
// rtl/cu_dcdr_pipe.sv - RV32 control-unit decoder feeding a QDEPTH-entry output queue; CU_DCDR_CSR_EN enables SYSTEM decode
module cu_dcdr_pipe #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_ir,
  input  logic [XLEN-1:0]           in_pc,
  input  logic                      flush,
  input  logic                      int_req,
  output logic                      int_ack,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [3:0]                alu_fun,
  output logic [1:0]                alu_srcA,
  output logic [2:0]                alu_srcB,
  output logic [1:0]                rf_wr_sel,
  output logic [2:0]                pc_src,
  output logic [2:0]                br_fun,
  output logic                      rf_we,
  output logic                      mem_we,
  output logic                      mem_rden,
  output logic                      is_branch,
  output logic                      illegal
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_fun;
    logic [1:0]      alu_srca;
    logic [2:0]      alu_srcb;
    logic [1:0]      rf_wr_sel;
    logic [2:0]      pc_src;
    logic [2:0]      br_fun;
    logic            rf_we;
    logic            mem_we;
    logic            mem_rden;
    logic            is_branch;
    logic            illegal;
  } entry_t;

  entry_t          mem [QDEPTH];
  entry_t          dec;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [2:0]      f3;
  logic            push;
  logic            pop;
  logic            unused_ir;

  // Only ir[30] of the upper funct7 matters to the ALU decode; the rest are don't-care here.
  assign unused_ir = ^{in_ir[31], in_ir[29:15], in_ir[11:7]};

  assign f3        = in_ir[14:12];
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush && !RST;
  assign pop       = out_valid && out_ready && !flush;
  assign int_ack   = push && int_req;

  // Combinational decode of the incoming instruction, or a trap entry when an interrupt is taken.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    if (int_req) begin
      dec.pc_src = 3'd4;
    end else begin
      case (in_ir[6:0])
        7'b0110011: begin
          dec.rf_we     = 1'b1;
          dec.rf_wr_sel = 2'd3;
          dec.alu_fun   = {in_ir[30], f3};
        end
        7'b0010011: begin
          dec.rf_we     = 1'b1;
          dec.rf_wr_sel = 2'd3;
          dec.alu_srcb  = 3'd1;
          dec.alu_fun   = {(f3 == 3'b101) ? in_ir[30] : 1'b0, f3};
        end
        7'b0000011: begin
          dec.rf_we     = 1'b1;
          dec.rf_wr_sel = 2'd2;
          dec.alu_srcb  = 3'd1;
          dec.mem_rden  = 1'b1;
        end
        7'b0100011: begin
          dec.alu_srcb = 3'd2;
          if (f3 > 3'b010) dec.illegal = 1'b1;
          else             dec.mem_we  = 1'b1;
        end
        7'b1100011: begin
          dec.is_branch = 1'b1;
          dec.br_fun    = f3;
          dec.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
        end
        7'b0110111: begin
          dec.rf_we     = 1'b1;
          dec.rf_wr_sel = 2'd3;
          dec.alu_srca  = 2'd1;
          dec.alu_fun   = 4'b1001;
        end
        7'b0010111: begin
          dec.rf_we     = 1'b1;
          dec.rf_wr_sel = 2'd3;
          dec.alu_srca  = 2'd1;
          dec.alu_srcb  = 3'd3;
        end
        7'b1101111: begin
          dec.rf_we  = 1'b1;
          dec.pc_src = 3'd3;
        end
        7'b1100111: begin
          if (f3 == 3'b000) begin
            dec.rf_we  = 1'b1;
            dec.pc_src = 3'd1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
`ifdef CU_DCDR_CSR_EN
        7'b1110011: begin
          if (in_ir == 32'h3020_0073) begin
            dec.pc_src = 3'd5;
          end else if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) begin
            dec.rf_we     = 1'b1;
            dec.rf_wr_sel = 2'd1;
          end else begin
            dec.illegal = 1'b1;
            dec.alu_fun = 4'b1111;
          end
        end
`endif
        default: begin
          dec.illegal = 1'b1;
          dec.alu_fun = 4'b1111;
        end
      endcase
    end
  end

  // Queue storage, pointers and occupancy; reset zeroes storage so an empty queue reads as all-zero fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_pc    = head.pc;
  assign alu_fun   = head.alu_fun;
  assign alu_srcA  = head.alu_srca;
  assign alu_srcB  = head.alu_srcb;
  assign rf_wr_sel = head.rf_wr_sel;
  assign pc_src    = head.pc_src;
  assign br_fun    = head.br_fun;
  assign rf_we     = head.rf_we;
  assign mem_we    = head.mem_we;
  assign mem_rden  = head.mem_rden;
  assign is_branch = head.is_branch;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_cu_dcdr_pipe.sv
// tb/tb_cu_dcdr_pipe.sv - table-driven decode vectors plus queue/flush/reset sequences for cu_dcdr_pipe
module tb_cu_dcdr_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_pc;
  logic        flush;
  logic        int_req;
  logic        int_ack;
  logic [1:0]  count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_fun;
  logic [1:0]  alu_srcA;
  logic [2:0]  alu_srcB;
  logic [1:0]  rf_wr_sel;
  logic [2:0]  pc_src;
  logic [2:0]  br_fun;
  logic        rf_we, mem_we, mem_rden, is_branch, illegal;

  int n_vec  = 0;
  int n_fail = 0;

  cu_dcdr_pipe #(.XLEN(32), .QDEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .int_req(int_req),
    .int_ack(int_ack), .count(count), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .alu_fun(alu_fun), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .rf_wr_sel(rf_wr_sel), .pc_src(pc_src), .br_fun(br_fun), .rf_we(rf_we),
    .mem_we(mem_we), .mem_rden(mem_rden), .is_branch(is_branch), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  // flags = {rf_we, mem_we, mem_rden, is_branch, illegal}
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        intr;
    logic [3:0]  alu;
    logic [1:0]  sa;
    logic [2:0]  sb;
    logic [1:0]  ws;
    logic [2:0]  ps;
    logic [2:0]  bf;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] ir, logic [31:0] pc, logic intr, logic [3:0] alu,
                              logic [1:0] sa, logic [2:0] sb, logic [1:0] ws, logic [2:0] ps,
                              logic [2:0] bf, logic [4:0] flags);
    vec_t v;
    v.ir = ir; v.pc = pc; v.intr = intr; v.alu = alu; v.sa = sa; v.sb = sb;
    v.ws = ws; v.ps = ps; v.bf = bf; v.flags = flags;
    return v;
  endfunction

  function automatic logic [63:0] obs();
    return {10'd0, out_pc, alu_fun, alu_srcA, alu_srcB, rf_wr_sel, pc_src, br_fun,
            rf_we, mem_we, mem_rden, is_branch, illegal};
  endfunction

  function automatic logic [63:0] expv(vec_t v);
    return {10'd0, v.pc, v.alu, v.sa, v.sb, v.ws, v.ps, v.bf, v.flags};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_one(logic [31:0] ir, logic [31:0] pc);
    @(negedge CLK);
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0;
    flush = 1'b0; int_req = 1'b0; out_ready = 1'b0;

    vecs.push_back(mk(32'h40B50533, 32'h1000, 0, 4'h8, 0, 0, 3, 0, 0, 5'b10000)); // sub
    vecs.push_back(mk(32'h00B50533, 32'h1004, 0, 4'h0, 0, 0, 3, 0, 0, 5'b10000)); // add
    vecs.push_back(mk(32'h00150513, 32'h1008, 0, 4'h0, 0, 1, 3, 0, 0, 5'b10000)); // addi
    vecs.push_back(mk(32'h40155513, 32'h100C, 0, 4'hD, 0, 1, 3, 0, 0, 5'b10000)); // srai
    vecs.push_back(mk(32'h0002A303, 32'h1010, 0, 4'h0, 0, 1, 2, 0, 0, 5'b10100)); // lw
    vecs.push_back(mk(32'h00A12023, 32'h1014, 0, 4'h0, 0, 2, 0, 0, 0, 5'b01000)); // sw
    vecs.push_back(mk(32'h00A13023, 32'h1018, 0, 4'h0, 0, 2, 0, 0, 0, 5'b00001)); // store f3=011
    vecs.push_back(mk(32'h00B50463, 32'h101C, 0, 4'h0, 0, 0, 0, 0, 0, 5'b00010)); // beq
    vecs.push_back(mk(32'h00B51463, 32'h1020, 0, 4'h0, 0, 0, 0, 0, 1, 5'b00010)); // bne
    vecs.push_back(mk(32'h00B52463, 32'h1024, 0, 4'h0, 0, 0, 0, 0, 2, 5'b00011)); // branch f3=010
    vecs.push_back(mk(32'h123452B7, 32'h1028, 0, 4'h9, 1, 0, 3, 0, 0, 5'b10000)); // lui
    vecs.push_back(mk(32'h00001297, 32'h102C, 0, 4'h0, 1, 3, 3, 0, 0, 5'b10000)); // auipc
    vecs.push_back(mk(32'h008000EF, 32'h1030, 0, 4'h0, 0, 0, 0, 3, 0, 5'b10000)); // jal
    vecs.push_back(mk(32'h000080E7, 32'h1034, 0, 4'h0, 0, 0, 0, 1, 0, 5'b10000)); // jalr
    vecs.push_back(mk(32'h000090E7, 32'h1038, 0, 4'h0, 0, 0, 0, 0, 0, 5'b00001)); // jalr f3=001
    vecs.push_back(mk(32'hFFFFFFFF, 32'h103C, 0, 4'hF, 0, 0, 0, 0, 0, 5'b00001)); // unknown
`ifdef CU_DCDR_CSR_EN
    vecs.push_back(mk(32'h30200073, 32'h1040, 0, 4'h0, 0, 0, 0, 5, 0, 5'b00000)); // mret
    vecs.push_back(mk(32'h34011073, 32'h1044, 0, 4'h0, 0, 0, 1, 0, 0, 5'b10000)); // csrrw
`else
    vecs.push_back(mk(32'h30200073, 32'h1040, 0, 4'hF, 0, 0, 0, 0, 0, 5'b00001)); // mret
    vecs.push_back(mk(32'h34011073, 32'h1044, 0, 4'hF, 0, 0, 0, 0, 0, 5'b00001)); // csrrw
`endif
    vecs.push_back(mk(32'h0002A303, 32'h0100, 1, 4'h0, 0, 0, 0, 4, 0, 5'b00000)); // trap on lw

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_count", {62'd0, count}, 64'd0);
    chk("reset_fields", obs(), 64'd0);
    int_req = 1'b1;
    #1;
    chk("idle_int_ack", {63'd0, int_ack}, 64'd0);
    int_req = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      in_valid = 1'b1; in_ir = vecs[i].ir; in_pc = vecs[i].pc;
      int_req = vecs[i].intr; out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_int_ack", i), {63'd0, int_ack}, {63'd0, vecs[i].intr});
      @(negedge CLK);
      in_valid = 1'b0; int_req = 1'b0;
      #1;
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_fields", i), obs(), expv(vecs[i]));
      if (vecs[i].intr) chk($sformatf("v%0d_ack_drop", i), {63'd0, int_ack}, 64'd0);
    end
    @(negedge CLK);
    #1;
    chk("drained_count", {62'd0, count}, 64'd0);

    // fill with out_ready low: third request must be refused
    out_ready = 1'b0;
    push_one(32'h40B50533, 32'h200);
    #1;
    chk("fill1_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_ir = 32'h00B50533; in_pc = 32'h204;
    @(negedge CLK);
    in_ir = 32'h00150513; in_pc = 32'h208;
    #1;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_count", {62'd0, count}, 64'd2);
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("full_count_hold", {62'd0, count}, 64'd2);
    chk("full_head_pc", {32'd0, out_pc}, 64'h200);
    chk("full_head_alu", {60'd0, alu_fun}, 64'h8);
    out_ready = 1'b1;
    @(negedge CLK);
    #1;
    chk("pop1_head_pc", {32'd0, out_pc}, 64'h204);
    chk("pop1_count", {62'd0, count}, 64'd1);

    // simultaneous push and pop keeps count
    in_valid = 1'b1; in_ir = 32'h123452B7; in_pc = 32'h20C;
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pushpop_count", {62'd0, count}, 64'd1);
    chk("pushpop_head_pc", {32'd0, out_pc}, 64'h20C);
    chk("pushpop_head_alu", {60'd0, alu_fun}, 64'h9);

    // fill to two, then flush alongside push, pop and interrupt
    push_one(32'h00B50533, 32'h210);
    #1;
    chk("preflush_count", {62'd0, count}, 64'd2);
    flush = 1'b1; in_valid = 1'b1; int_req = 1'b1; out_ready = 1'b1;
    in_ir = 32'h00B50533; in_pc = 32'h214;
    #1;
    chk("flush_int_ack", {63'd0, int_ack}, 64'd0);
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0; int_req = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_count", {62'd0, count}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);

    // reset mid-operation with a full queue and a pending push
    push_one(32'h40B50533, 32'h300);
    push_one(32'h00150513, 32'h304);
    #1;
    chk("prerst_count", {62'd0, count}, 64'd2);
    RST = 1'b1; in_valid = 1'b1; in_ir = 32'h00B50533; in_pc = 32'h308;
    @(negedge CLK);
    RST = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_count", {62'd0, count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fields", obs(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
